hazard_controller: RTL and testbench
====================================

Name: hazard_controller

Overview:
Central pipeline scheduler for the 5-stage RV32 core. It generates the per-stage stall and flush strobes, including the decode-stage `StallD`/`PipelineFlush` pair, and the EX-stage operand forwarding selects. It sequences four activities:
- post-reset boot hold
- load-use bubbles
- taken-branch flushes
- multi-cycle data-memory waits, with timeout detection

Parameters:
BOOT_CYCLES, 4, cycles the pipeline is held stalled after reset release (1..15)
MEM_TIMEOUT, 255, max consecutive MEM_WAIT cycles before mem_err is raised (1..65535)
CNT_W, 16, width of internal wait counter; must hold MEM_TIMEOUT

Ports:
clk  in  1  core clock
rst  in  1  reset, asynchronous, active-low
rs1_d  in  5  rs1 field of instruction in D
rs2_d  in  5  rs2 field of instruction in D
rs1_e  in  5  rs1 of instruction in E
rs2_e  in  5  rs2 of instruction in E
rd_e  in  5  destination register in E
mem_read_e  in  1  instruction in E is a load
rd_m  in  5  destination register in M
reg_write_m  in  1  M writes register file
rd_w  in  5  destination register in W
reg_write_w  in  1  W writes register file
branch_taken_e  in  1  E resolved a taken branch/jump
mem_req_m  in  1  M issues data-memory access this cycle
mem_ready_m  in  1  data memory completes access this cycle
stall_f  out  1  hold PC/fetch
stall_d  out  1  hold IF/ID register; drives decode `StallD`
stall_e  out  1  hold ID/EX register
stall_m  out  1  hold EX/MEM and MEM/WB registers
flush_d  out  1  clear IF/ID register
flush_e  out  1  clear ID/EX register; drives decode `PipelineFlush`
fwd_a_e  out  2  EX operand A select: 00 regfile, 01 W result, 10 M ALU result
fwd_b_e  out  2  EX operand B select, same encoding
mem_err  out  1  sticky memory-timeout flag
state_o  out  2  current FSM state
stall_cycles  out  32  perf counter (see Optional Feature)
flush_count  out  32  perf counter (see Optional Feature)

Behaviour:
- FSM states: BOOT=00, RUN=01, MEM_WAIT=10, ERR=11. State, boot counter, wait counter and mem_err are registered; all other outputs are combinational from state plus inputs.
- Reset (rst low, async):
  - state=BOOT, boot counter=BOOT_CYCLES, wait counter=0, mem_err=0.
  - Outputs while rst is low: stall_f=stall_d=stall_e=stall_m=1, flush_d=flush_e=0, fwd_*=00.
- BOOT:
  - All stalls=1, flushes=0.
  - Counter decrements each cycle; at 1 go to RUN.
  - Exactly BOOT_CYCLES stalled cycles follow reset release.
- RUN, priority order (highest first):
  1. Memory wait: mem_req_m && !mem_ready_m.
     - Assert all four stalls, flushes=0. This also suppresses branch flush and load-use handling.
     - Wait counter <= 1; go to MEM_WAIT.
  2. Taken branch: branch_taken_e.
     - flush_d=1, flush_e=1, stalls=0.
     - Overrides a simultaneous load-use hazard.
  3. Load-use: mem_read_e && rd_e!=0 && (rd_e==rs1_d || rd_e==rs2_d).
     - stall_f=1, stall_d=1, flush_e=1 for one cycle.
     - Stay in RUN; no extra state is required since the load advances to M.
  4. Otherwise all stalls and flushes are 0.
- MEM_WAIT:
  - All four stalls=1, flushes=0.
  - mem_ready_m=1: outputs still stalled this cycle; next state RUN; wait counter cleared.
  - Else wait counter increments. When the counter reaches MEM_TIMEOUT without ready: set mem_err and go to ERR.
  - A branch_taken_e seen during MEM_WAIT is not acted on. E is frozen, so the branch re-presents after resume.
- ERR:
  - All stalls=1, flushes=0, mem_err=1.
  - Exit only by reset.
- Forwarding (all states):
  - fwd_a_e=10 if reg_write_m && rd_m!=0 && rd_m==rs1_e.
  - Else 01 if reg_write_w && rd_w!=0 && rd_w==rs1_e.
  - Else 00. fwd_b_e is the same using rs2_e.
  - M takes precedence over W. Register x0 is never forwarded.
- Invariant: flush_x and stall_x are never both 1 for the same register.

Optional Feature:
Macro HAZARD_PERF_CNT_EN.
- Defined:
  - stall_cycles increments every cycle stall_f=1 outside BOOT.
  - flush_count increments every cycle flush_d=1.
  - Both are 32-bit, wrap from 0xFFFFFFFF to 0, and reset to 0.
- Undefined: both ports are driven constant 0 and no counter flops are built.

Test Plan:
- Reset release with BOOT_CYCLES=4 -> stall_f=1 for exactly 4 cycles, then state_o=01 and stall_f=0.
- Load x5 in E (mem_read_e=1, rd_e=5), rs2_d=5 -> one cycle of stall_f=stall_d=flush_e=1, then all 0.
- rd_m=3 with reg_write_m=1 and rd_w=3 with reg_write_w=1, rs1_e=3 -> fwd_a_e=10; with rd_m=0 instead -> fwd_a_e=01; with rs1_e=0 -> fwd_a_e=00.
- branch_taken_e=1 together with a load-use hazard -> flush_d=flush_e=1, stall_f=0; flush_count increments by 1 when HAZARD_PERF_CNT_EN is defined.
- mem_req_m=1 with mem_ready_m low for 3 cycles, then high, plus branch_taken_e=1 during the wait -> 4 fully stalled cycles, no flush, back to RUN.
- MEM_TIMEOUT=8 with mem_ready_m stuck at 0 -> mem_err=1 and state_o=11 after the timeout; async rst low mid-ERR -> state_o=00 and mem_err=0 immediately.

Source files
------------

// File: rtl/hazard_controller.sv
// Pipeline stall/flush/forwarding scheduler for the 5-stage RV32 core.
// Optional perf counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_controller #(
  parameter int BOOT_CYCLES = 4,
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  rs1_d,
  input  logic [4:0]  rs2_d,
  input  logic [4:0]  rs1_e,
  input  logic [4:0]  rs2_e,
  input  logic [4:0]  rd_e,
  input  logic        mem_read_e,
  input  logic [4:0]  rd_m,
  input  logic        reg_write_m,
  input  logic [4:0]  rd_w,
  input  logic        reg_write_w,
  input  logic        branch_taken_e,
  input  logic        mem_req_m,
  input  logic        mem_ready_m,
  output logic        stall_f,
  output logic        stall_d,
  output logic        stall_e,
  output logic        stall_m,
  output logic        flush_d,
  output logic        flush_e,
  output logic [1:0]  fwd_a_e,
  output logic [1:0]  fwd_b_e,
  output logic        mem_err,
  output logic [1:0]  state_o,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count
);

  typedef enum logic [1:0] {BOOT = 2'b00, RUN = 2'b01, MEM_WAIT = 2'b10, ERR = 2'b11} state_t;

  localparam logic [3:0]       BOOT_INIT  = 4'(BOOT_CYCLES);
  localparam logic [CNT_W-1:0] TIMEOUT_M1 = CNT_W'(MEM_TIMEOUT - 1);

  state_t           state;
  logic [3:0]       bootCnt;
  logic [CNT_W-1:0] waitCnt;
  logic             memErrQ;
  logic             memWait;
  logic             loadUse;

  assign memWait = mem_req_m && !mem_ready_m;
  assign loadUse = mem_read_e && (rd_e != 5'd0) && ((rd_e == rs1_d) || (rd_e == rs2_d));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= BOOT;
      bootCnt <= BOOT_INIT;
      waitCnt <= '0;
      memErrQ <= 1'b0;
    end else begin
      case (state)
        BOOT: begin
          if (bootCnt <= 4'd1) state <= RUN;
          else bootCnt <= bootCnt - 4'd1;
        end
        RUN: begin
          if (memWait) begin
            waitCnt <= CNT_W'(1);
            state   <= MEM_WAIT;
          end
        end
        MEM_WAIT: begin
          if (mem_ready_m) begin
            waitCnt <= '0;
            state   <= RUN;
          end else begin
            // The RUN cycle that entered MEM_WAIT already counted as wait cycle 1.
            waitCnt <= waitCnt + CNT_W'(1);
            if (waitCnt >= TIMEOUT_M1) begin
              memErrQ <= 1'b1;
              state   <= ERR;
            end
          end
        end
        default: state <= ERR;
      endcase
    end
  end

  // Stall/flush valid/ready contract: a stall holds the stage register, a flush clears it;
  // the two are never raised together for the same register.
  always_comb begin
    stall_f = 1'b1;
    stall_d = 1'b1;
    stall_e = 1'b1;
    stall_m = 1'b1;
    flush_d = 1'b0;
    flush_e = 1'b0;
    if (state == RUN && !memWait) begin
      stall_e = 1'b0;
      stall_m = 1'b0;
      if (branch_taken_e) begin
        stall_f = 1'b0;
        stall_d = 1'b0;
        flush_d = 1'b1;
        flush_e = 1'b1;
      end else if (loadUse) begin
        flush_e = 1'b1;
      end else begin
        stall_f = 1'b0;
        stall_d = 1'b0;
      end
    end
  end

  always_comb begin
    fwd_a_e = 2'b00;
    fwd_b_e = 2'b00;
    if (reg_write_m && rd_m != 5'd0 && rd_m == rs1_e)      fwd_a_e = 2'b10;
    else if (reg_write_w && rd_w != 5'd0 && rd_w == rs1_e) fwd_a_e = 2'b01;
    if (reg_write_m && rd_m != 5'd0 && rd_m == rs2_e)      fwd_b_e = 2'b10;
    else if (reg_write_w && rd_w != 5'd0 && rd_w == rs2_e) fwd_b_e = 2'b01;
  end

  assign mem_err = memErrQ;
  assign state_o = state;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stallCnt;
  logic [31:0] flushCnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stallCnt <= '0;
      flushCnt <= '0;
    end else begin
      if (stall_f && state != BOOT) stallCnt <= stallCnt + 32'd1;
      if (flush_d) flushCnt <= flushCnt + 32'd1;
    end
  end

  assign stall_cycles = stallCnt;
  assign flush_count  = flushCnt;
`else
  assign stall_cycles = 32'd0;
  assign flush_count  = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller (BOOT_CYCLES=4, MEM_TIMEOUT=8).
module tb_hazard_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic        mem_read_e, reg_write_m, reg_write_w, branch_taken_e, mem_req_m, mem_ready_m;
  logic        stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, mem_err;
  logic [1:0]  fwd_a_e, fwd_b_e, state_o;
  logic [31:0] stall_cycles, flush_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  hazard_controller #(.BOOT_CYCLES(4), .MEM_TIMEOUT(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
    .mem_read_e(mem_read_e), .rd_m(rd_m), .reg_write_m(reg_write_m),
    .rd_w(rd_w), .reg_write_w(reg_write_w), .branch_taken_e(branch_taken_e),
    .mem_req_m(mem_req_m), .mem_ready_m(mem_ready_m),
    .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
    .flush_d(flush_d), .flush_e(flush_e), .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e),
    .mem_err(mem_err), .state_o(state_o),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // stalls packed as {f,d,e,m}, flushes as {d,e}
  task automatic chk_ctl(input string tag, input logic [3:0] stalls, input logic [1:0] flushes);
    chk({tag, ".stall"}, {28'd0, stall_f, stall_d, stall_e, stall_m}, {28'd0, stalls});
    chk({tag, ".flush"}, {30'd0, flush_d, flush_e}, {30'd0, flushes});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    {rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w} = '0;
    {mem_read_e, reg_write_m, reg_write_w, branch_taken_e, mem_req_m, mem_ready_m} = '0;

    #1;
    chk("rst.state", 32'(state_o), 32'd0);
    chk("rst.mem_err", 32'(mem_err), 32'd0);
    chk_ctl("rst", 4'b1111, 2'b00);
    chk("rst.fwd_a", 32'(fwd_a_e), 32'd0);

    // Boot hold: exactly 4 stalled cycles after release.
    #11 rst = 1'b1;
    #1;
    chk_ctl("boot0", 4'b1111, 2'b00);
    for (int i = 1; i < 4; i++) begin
      tick();
      chk("boot.state", 32'(state_o), 32'd0);
      chk_ctl("boot", 4'b1111, 2'b00);
    end
    tick();
    chk("run.state", 32'(state_o), 32'd1);
    chk_ctl("run", 4'b0000, 2'b00);

    // Load-use on rs2_d.
    mem_read_e = 1'b1; rd_e = 5'd5; rs2_d = 5'd5;
    #1;
    chk_ctl("loaduse", 4'b1100, 2'b01);
    tick();
    mem_read_e = 1'b0;
    #1;
    chk_ctl("loaduse.after", 4'b0000, 2'b00);
    chk("loaduse.state", 32'(state_o), 32'd1);

    // Load-use with rd_e = x0 is not a hazard.
    mem_read_e = 1'b1; rd_e = 5'd0; rs1_d = 5'd0;
    #1;
    chk_ctl("loaduse.x0", 4'b0000, 2'b00);
    mem_read_e = 1'b0; rs1_d = 5'd0; rs2_d = 5'd0;

    // Forwarding priority and x0.
    rd_m = 5'd3; reg_write_m = 1'b1; rd_w = 5'd3; reg_write_w = 1'b1; rs1_e = 5'd3;
    #1 chk("fwd.m", 32'(fwd_a_e), 32'd2);
    rd_m = 5'd0;
    #1 chk("fwd.w", 32'(fwd_a_e), 32'd1);
    rs1_e = 5'd0;
    #1 chk("fwd.x0", 32'(fwd_a_e), 32'd0);
    rd_m = 5'd7; rs2_e = 5'd7;
    #1 chk("fwd.b_m", 32'(fwd_b_e), 32'd2);
    reg_write_m = 1'b0;
    #1 chk("fwd.b_nowrite", 32'(fwd_b_e), 32'd0);
    {rd_m, rd_w, rs1_e, rs2_e} = '0; reg_write_m = 1'b0; reg_write_w = 1'b0;

    // Branch beats load-use.
    tick();
    branch_taken_e = 1'b1; mem_read_e = 1'b1; rd_e = 5'd5; rs2_d = 5'd5;
    #1;
    chk_ctl("branch", 4'b0000, 2'b11);
    tick();
    branch_taken_e = 1'b0; mem_read_e = 1'b0; rs2_d = 5'd0;
    #1;
`ifdef HAZARD_PERF_CNT_EN
    chk("branch.flush_count", flush_count, 32'd1);
`else
    chk("branch.flush_count", flush_count, 32'd0);
`endif

    // Memory wait: 3 not-ready cycles then ready, branch ignored throughout.
    mem_req_m = 1'b1; mem_ready_m = 1'b0; branch_taken_e = 1'b1;
    #1;
    chk("mw1.state", 32'(state_o), 32'd1);
    chk_ctl("mw1", 4'b1111, 2'b00);
    tick();
    chk("mw2.state", 32'(state_o), 32'd2);
    chk_ctl("mw2", 4'b1111, 2'b00);
    tick();
    chk_ctl("mw3", 4'b1111, 2'b00);
    tick();
    mem_ready_m = 1'b1;
    #1;
    chk("mw4.state", 32'(state_o), 32'd2);
    chk_ctl("mw4", 4'b1111, 2'b00);
    tick();
    mem_req_m = 1'b0; mem_ready_m = 1'b0; branch_taken_e = 1'b0;
    #1;
    chk("mw.resume", 32'(state_o), 32'd1);
    chk_ctl("mw.resume", 4'b0000, 2'b00);
`ifdef HAZARD_PERF_CNT_EN
    chk("perf.stall_cycles", stall_cycles, 32'd5);
`else
    chk("perf.stall_cycles", stall_cycles, 32'd0);
`endif

    // Timeout: 8 consecutive wait cycles then ERR.
    mem_req_m = 1'b1; mem_ready_m = 1'b0;
    #1;
    for (int i = 1; i < 8; i++) begin
      tick();
      chk("to.state", 32'(state_o), 32'd2);
      chk("to.mem_err", 32'(mem_err), 32'd0);
    end
    tick();
    chk("err.state", 32'(state_o), 32'd3);
    chk("err.mem_err", 32'(mem_err), 32'd1);
    chk_ctl("err", 4'b1111, 2'b00);
    mem_ready_m = 1'b1;
    tick();
    chk("err.sticky", 32'(state_o), 32'd3);

    // Asynchronous reset away from the clock edge.
    #2 rst = 1'b0;
    #1;
    chk("arst.state", 32'(state_o), 32'd0);
    chk("arst.mem_err", 32'(mem_err), 32'd0);
    chk_ctl("arst", 4'b1111, 2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
